// File: rtl/apb_xbar_pkg.sv
// Shared state encoding and slave-index helpers for the APB decoder / response mux.
package apb_xbar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TOUT   = 2'd2
  } apb_xbar_state_e;

  // Wide enough to hold any legal slave-index field (SEL_W <= 16).
  localparam int unsigned SLV_IDX_W = 16;
  typedef logic [SLV_IDX_W-1:0] slv_idx_t;

  function automatic logic idx_mapped(slv_idx_t idx, int unsigned n);
    return 32'(idx) < n;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expire_o flags the last wait cycle before abort.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_EXP = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CNT_EXP);

endmodule

// File: rtl/apb_xbar_dec.sv
// APB one-master / NUM_SLAVES-slave decoder and response mux with a default
// error slave for unmapped addresses, a PREADY timeout and a protocol checker.
module apb_xbar_dec
  import apb_xbar_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SEL_LSB    = 12,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [NUM_SLAVES-1:0]        PSEL_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA_S,
  input  logic [NUM_SLAVES-1:0]        PREADY_S,
  input  logic [NUM_SLAVES-1:0]        PSLVERR_S,
  input  logic                         prot_clr,
  output logic                         prot_err,
  output logic                         decerr_evt,
  output logic                         timeout_evt
);

  apb_xbar_state_e   state_q, state_d;
  logic [SEL_W-1:0]  live_idx, idx_q, idx_d;
  slv_idx_t          live_idx_ext;
  logic              live_mapped, mapped_q, mapped_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic              prot_err_q, prot_err_d;

  logic                  setup, in_acc, acc_ok, abort, tout_hit, viol;
  logic                  slv_ready, slv_err, expire, tmr_clr, tmr_en;
  logic [DATA_W-1:0]     slv_rdata;
  logic [NUM_SLAVES-1:0] live_oh, q_oh;
  logic                  unused_pwdata;

  // Write data goes straight from master to slaves; the decoder never looks at it.
  assign unused_pwdata = ^PWDATA;

  assign live_idx = PADDR[SEL_LSB +: SEL_W];

  always_comb begin
    live_idx_ext = '0;
    live_idx_ext[SEL_W-1:0] = live_idx;
  end

  assign live_mapped = idx_mapped(live_idx_ext, NUM_SLAVES);

  always_comb begin
    live_oh   = '0;
    q_oh      = '0;
    slv_rdata = '0;
    slv_ready = 1'b0;
    slv_err   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (live_idx == SEL_W'(i)) live_oh[i] = 1'b1;
      if (idx_q == SEL_W'(i)) begin
        q_oh[i]   = 1'b1;
        slv_rdata = PRDATA_S[i*DATA_W +: DATA_W];
        slv_ready = PREADY_S[i];
        slv_err   = PSLVERR_S[i];
      end
    end
  end

  assign in_acc   = (state_q == ACCESS);
  assign setup    = PSEL & ~PENABLE & (state_q == IDLE);
  assign acc_ok   = in_acc & PSEL & PENABLE;
  assign abort    = in_acc & ~(PSEL & PENABLE);
  assign tmr_clr  = setup;
  assign tmr_en   = acc_ok & mapped_q & ~slv_ready;
  // Late ready beats expiry: tmr_en already excludes a ready slave.
  assign tout_hit = tmr_en & expire;

  if (TIMEOUT > 0) begin : g_timer
    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk_i    (PCLK),
      .rst_ni   (PRESETn),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .expire_o (expire)
    );
  end else begin : g_no_timer
    assign expire = 1'b0;
  end

  assign viol = ((state_q == IDLE) & PENABLE)
              | abort
              | (acc_ok & ((PADDR != addr_q) | (PWRITE != write_q)));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mapped_d   = mapped_q;
    addr_d     = addr_q;
    write_d    = write_q;
    prot_err_d = viol | (prot_err_q & ~prot_clr);
    case (state_q)
      IDLE:    if (setup) state_d = ACCESS;
      ACCESS: begin
        if (abort || !mapped_q || slv_ready) state_d = IDLE;
        else if (tout_hit)                   state_d = TOUT;
      end
      TOUT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (setup) begin
      idx_d    = live_idx;
      mapped_d = live_mapped;
      addr_d   = PADDR;
      write_d  = PWRITE;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      mapped_q   <= 1'b0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mapped_q   <= mapped_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      prot_err_q <= prot_err_d;
    end
  end

  always_comb begin
    PSEL_S  = '0;
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    case (state_q)
      IDLE: if (setup) PSEL_S = live_oh;
      ACCESS: begin
        if (acc_ok) begin
          if (mapped_q) begin
            PSEL_S  = q_oh;
            PREADY  = slv_ready;
            PSLVERR = slv_err;
            PRDATA  = slv_rdata;
          end else begin
            PSLVERR = 1'b1;
          end
        end
      end
      TOUT:    PSLVERR = 1'b1;
      default: ;
    endcase
    // The setup decode is combinational, so it must be masked during reset.
    if (!PRESETn) PSEL_S = '0;
  end

  assign decerr_evt  = acc_ok & ~mapped_q;
  assign timeout_evt = (state_q == TOUT);
  assign prot_err    = prot_err_q;

endmodule

// File: tb/tb_apb_xbar_dec.sv
// Directed bench for apb_xbar_dec: 4 slaves, SEL_LSB=12, TIMEOUT=8.
module tb_apb_xbar_dec;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic [AW-1:0]    PADDR;
  logic             PSEL, PENABLE, PWRITE;
  logic [DW-1:0]    PWDATA;
  logic [DW-1:0]    PRDATA;
  logic             PREADY, PSLVERR;
  logic [NS-1:0]    PSEL_S;
  logic [NS*DW-1:0] PRDATA_S;
  logic [NS-1:0]    PREADY_S, PSLVERR_S;
  logic             prot_clr, prot_err, decerr_evt, timeout_evt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 PCLK = ~PCLK;

  apb_xbar_dec #(
    .NUM_SLAVES (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .SEL_LSB    (12),
    .SEL_W      (4),
    .TIMEOUT    (8)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .PSEL_S      (PSEL_S),
    .PRDATA_S    (PRDATA_S),
    .PREADY_S    (PREADY_S),
    .PSLVERR_S   (PSLVERR_S),
    .prot_clr    (prot_clr),
    .prot_err    (prot_err),
    .decerr_evt  (decerr_evt),
    .timeout_evt (timeout_evt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge PCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn   = 1'b0;
    PSEL      = 1'b1;
    PENABLE   = 1'b0;
    PADDR     = 32'h0000_1000;
    PWRITE    = 1'b0;
    PWDATA    = 32'h0;
    PRDATA_S  = {32'hA5A5_0003, 32'h2222_2222, 32'h1111_1111, 32'h1010_1010};
    PREADY_S  = 4'b0000;
    PSLVERR_S = 4'b0000;
    prot_clr  = 1'b0;

    // Reset: setup decode is gated, responses at idle defaults.
    smp();
    chk("rst_psel_s",  32'(PSEL_S),      32'h0);
    chk("rst_pready",  32'(PREADY),      32'h1);
    chk("rst_pslverr", 32'(PSLVERR),     32'h0);
    chk("rst_prdata",  PRDATA,           32'h0);
    chk("rst_prot",    32'(prot_err),    32'h0);
    chk("rst_decerr",  32'(decerr_evt),  32'h0);
    chk("rst_tout",    32'(timeout_evt), 32'h0);
    PSEL = 1'b0;
    cyc();
    PRESETn = 1'b1;

    // Write 0xDEADBEEF to slave 1, zero wait.
    cyc();
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_1004; PWRITE = 1'b1;
    PWDATA = 32'hDEAD_BEEF; PREADY_S = 4'b0010;
    smp();
    chk("wr_setup_psel_s", 32'(PSEL_S), 32'h2);
    cyc();
    PENABLE = 1'b1;
    smp();
    chk("wr_acc_psel_s",  32'(PSEL_S),  32'h2);
    chk("wr_acc_pready",  32'(PREADY),  32'h1);
    chk("wr_acc_pslverr", 32'(PSLVERR), 32'h0);
    cyc();
    PSEL = 1'b0; PENABLE = 1'b0; PREADY_S = 4'b0000;

    // Read slave 3 with 3 wait states.
    cyc();
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_3010; PWRITE = 1'b0;
    smp();
    chk("rd_setup_psel_s", 32'(PSEL_S), 32'h8);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      PENABLE  = 1'b1;
      PREADY_S = (c == 4) ? 4'b1000 : 4'b0000;
      smp();
      chk($sformatf("rd_pready_c%0d", c), 32'(PREADY), 32'(c == 4));
    end
    chk("rd_prdata",     PRDATA,          32'hA5A5_0003);
    chk("rd_pslverr",    32'(PSLVERR),    32'h0);
    chk("rd_acc_psel_s", 32'(PSEL_S),     32'h8);
    cyc();
    PSEL = 1'b0; PENABLE = 1'b0; PREADY_S = 4'b0000;

    // Unmapped read: default slave answers with an error.
    cyc();
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_5000;
    smp();
    chk("unm_setup_psel_s", 32'(PSEL_S),     32'h0);
    chk("unm_setup_decerr", 32'(decerr_evt), 32'h0);
    cyc();
    PENABLE = 1'b1;
    smp();
    chk("unm_psel_s",  32'(PSEL_S),     32'h0);
    chk("unm_pready",  32'(PREADY),     32'h1);
    chk("unm_pslverr", 32'(PSLVERR),    32'h1);
    chk("unm_prdata",  PRDATA,          32'h0);
    chk("unm_decerr",  32'(decerr_evt), 32'h1);
    cyc();
    PSEL = 1'b0; PENABLE = 1'b0;
    smp();
    chk("unm_decerr_pulse", 32'(decerr_evt), 32'h0);
    chk("unm_idle_pslverr", 32'(PSLVERR),    32'h0);

    // Slave 2 never ready: timeout in access cycle 9, then back-to-back to slave 0.
    cyc();
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_2000;
    smp();
    chk("to_setup_psel_s", 32'(PSEL_S), 32'h4);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      PENABLE = 1'b1;
      smp();
      chk($sformatf("to_pready_c%0d", c), 32'(PREADY), 32'h0);
      chk($sformatf("to_psel_s_c%0d", c), 32'(PSEL_S), 32'h4);
    end
    cyc();
    smp();
    chk("to_psel_s",  32'(PSEL_S),      32'h0);
    chk("to_pready",  32'(PREADY),      32'h1);
    chk("to_pslverr", 32'(PSLVERR),     32'h1);
    chk("to_prdata",  PRDATA,           32'h0);
    chk("to_evt",     32'(timeout_evt), 32'h1);
    cyc();
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_0000; PREADY_S = 4'b0001;
    smp();
    chk("to_evt_pulse",     32'(timeout_evt), 32'h0);
    chk("s0_setup_psel_s",  32'(PSEL_S),      32'h1);
    cyc();
    PENABLE = 1'b1;
    smp();
    chk("s0_pready",  32'(PREADY),  32'h1);
    chk("s0_prdata",  PRDATA,       32'h1010_1010);
    chk("s0_pslverr", 32'(PSLVERR), 32'h0);
    chk("s0_prot",    32'(prot_err), 32'h0);
    cyc();
    PSEL = 1'b0; PENABLE = 1'b0; PREADY_S = 4'b0000;

    // PADDR changes mid-access.
    cyc();
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_0000; PWRITE = 1'b0;
    cyc();
    PENABLE = 1'b1;
    smp();
    chk("prot_a1", 32'(prot_err), 32'h0);
    cyc();
    PADDR = 32'h0000_0004;
    smp();
    chk("prot_a2", 32'(prot_err), 32'h0);
    cyc();
    PREADY_S = 4'b0001;
    smp();
    chk("prot_set", 32'(prot_err), 32'h1);
    cyc();
    PSEL = 1'b0; PENABLE = 1'b0; PADDR = 32'h0; PREADY_S = 4'b0000;
    cyc();
    cyc();
    smp();
    chk("prot_sticky", 32'(prot_err), 32'h1);
    cyc();
    prot_clr = 1'b1;
    cyc();
    prot_clr = 1'b0;
    smp();
    chk("prot_cleared", 32'(prot_err), 32'h0);

    // Stray PENABLE in idle; clear coinciding with a violation keeps the flag.
    cyc();
    PENABLE = 1'b1;
    smp();
    chk("stray_before", 32'(prot_err), 32'h0);
    cyc();
    prot_clr = 1'b1;
    smp();
    chk("stray_set", 32'(prot_err), 32'h1);
    cyc();
    PENABLE = 1'b0;
    smp();
    chk("clr_vs_viol", 32'(prot_err), 32'h1);
    cyc();
    prot_clr = 1'b0;
    smp();
    chk("clr_done", 32'(prot_err), 32'h0);

    // Reset during a slave-1 wait state, then a clean write.
    cyc();
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_1000; PWRITE = 1'b1;
    cyc();
    PENABLE = 1'b1;
    smp();
    chk("mid_psel_s", 32'(PSEL_S), 32'h2);
    chk("mid_pready", 32'(PREADY), 32'h0);
    #2 PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel_s", 32'(PSEL_S),      32'h0);
    chk("mid_rst_pready", 32'(PREADY),      32'h1);
    chk("mid_rst_tout",   32'(timeout_evt), 32'h0);
    chk("mid_rst_decerr", 32'(decerr_evt),  32'h0);
    cyc();
    PSEL = 1'b0; PENABLE = 1'b0;
    #2 PRESETn = 1'b1;
    cyc();
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_1000; PREADY_S = 4'b0010;
    smp();
    chk("post_setup_psel_s", 32'(PSEL_S), 32'h2);
    cyc();
    PENABLE = 1'b1;
    smp();
    chk("post_pready",  32'(PREADY),   32'h1);
    chk("post_pslverr", 32'(PSLVERR),  32'h0);
    chk("post_prot",    32'(prot_err), 32'h0);
    cyc();
    PSEL = 1'b0; PENABLE = 1'b0; PREADY_S = 4'b0000;
    smp();
    chk("post_idle_psel_s", 32'(PSEL_S), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
